accum_bank: RTL and testbench
=============================

Name: accum_bank

Overview:
- Parametrised multi-accumulator register bank for the microprocessor datapath.
- Holds N_ACC accumulators of WIDTH bits and captures the ALU result Z into a selected accumulator.
- Also provides in-place clear, increment/decrement and multi-cycle shift/rotate, with registered Z/N/C status flags.
- The selected accumulator is fed back to the ALU input through the ac output.

Parameters:
- WIDTH, 8, data width of each accumulator and of z/ac.
- N_ACC, 4, number of accumulators (≥1); SEL_W = max(1,$clog2(N_ACC)).
- SH_W, $clog2(WIDTH), width of shift amount.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- z  in  WIDTH  ALU result for LOAD.
- start  in  1  command strobe, sampled only in IDLE.
- op  in  3  command code (accum_pkg::acc_op_e).
- sel  in  SEL_W  target accumulator for commands and ac read select.
- shamt  in  SH_W  shift/rotate count.
- busy  out  1  multi-cycle shift in progress.
- ac  out  WIDTH  combinational read of acc[sel]; 0 if sel ≥ N_ACC.
- flag_z  out  1  last result == 0.
- flag_n  out  1  last result MSB.
- flag_c  out  1  carry/borrow/last bit shifted out.

Behaviour:
- Reset (async, rst_n=0):
  - all acc[i]=0.
  - flag_z=1, flag_n=0, flag_c=0.
  - busy=0, FSM=IDLE, shift counter=0.
  - Takes effect immediately, including mid-shift (the shift is aborted, no partial result kept).
- Op codes: NOP=0, LOAD=1, CLR=2, INC=3, DEC=4, SHL=5, SHR=6 (logical), ROL=7.
- FSM IDLE, start=1, sel<N_ACC:
  - LOAD/CLR/INC/DEC: acc[sel] is updated at the next clk edge (1-cycle latency); flags are updated at the same edge.
  - LOAD and CLR clear flag_c.
  - INC: all-ones wraps to 0 with C=1, otherwise C=0.
  - DEC: 0 wraps to all-ones with C=1 (borrow), otherwise C=0.
  - SHL/SHR/ROL with shamt=0: completes in 1 cycle; value unchanged, Z/N recomputed, C=0, no busy.
  - SHL/SHR/ROL with shamt>0: latch op, sel and count=shamt, then go to SHIFT; busy=1 from the next cycle.
- FSM SHIFT:
  - Each cycle, acc[latched sel] moves one bit; count decrements.
  - When count reaches 0, go to IDLE; busy drops in the same cycle the final shifted value becomes visible.
  - Total latency is shamt cycles.
  - flag_c = last bit shifted/rotated out; Z/N are updated only at completion.
- Ignored / no-change cases:
  - start with op=NOP, start=0, or sel ≥ N_ACC: no state or flag change.
  - start while busy=1: ignored, no queuing.
- ac always tracks the live sel input, including during SHIFT, where intermediate values are visible.
- Other accumulators are never modified by a command targeting a different index.

Optional Feature:
- Macro: ACCUM_SAT_EN.
- Defined: INC saturates at all-ones and DEC saturates at 0; flag_c=1 when saturation blocked the update, else 0.
- Undefined: wrap-around as described above.

Decomposition:
- Package accum_pkg:
  - acc_op_e enum (3-bit).
  - acc_state_e (IDLE, SHIFT).
  - localparam helper for SEL_W.
- Sub-module accum_shift1:
  - Combinational one-bit SHL/SHR/ROL step returning {carry_out, value}.
  - Reused for the single step each SHIFT cycle.
- Flag computation stays inline.

Test Plan:
- Reset: hold rst_n=0 → all ac=0x00, Z=1, N=0, C=0, busy=0.
- LOAD: LOAD z=0x80 sel=1 → next cycle ac(sel=1)=0x80, N=1, Z=0, C=0; ac(sel=0) still 0x00.
- INC wrap: LOAD 0xFF sel=2, then INC → 0x00, Z=1, C=1. With ACCUM_SAT_EN: 0xFF, C=1, Z=0.
- SHL: LOAD 0xB1, then SHL shamt=3 → busy high 3 cycles, intermediates 0x62, 0xC4, final 0x88, C=1, N=1. A start issued mid-shift is ignored.
- ROL: LOAD 0x3C sel=3, then ROL shamt=4 → 0xC3 after 4 cycles, C=1, busy then 0.
- Reset mid-shift: SHR shamt=5 on 0xF0, drop rst_n after 2 cycles → busy=0 immediately, all accumulators 0x00, Z=1; next LOAD works normally.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared types for the accumulator bank: command codes, FSM states and the
// select-width helper.
package accum_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_LOAD = 3'd1,
      OP_CLR  = 3'd2,
      OP_INC  = 3'd3,
      OP_DEC  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6,
      OP_ROL  = 3'd7
   } acc_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } acc_state_e;

   // A single accumulator still needs a 1-bit select port.
   function automatic int sel_width(input int n_acc);
      return (n_acc > 1) ? $clog2(n_acc) : 1;
   endfunction

   localparam int DEFAULT_N_ACC = 4;
   localparam int DEFAULT_SEL_W = sel_width(DEFAULT_N_ACC);

endpackage

// File: rtl/accum_shift1.sv
// Combinational one-bit shift/rotate step: logical SHL, logical SHR, ROL.
// Any other op passes the value through with carry_out = 0.
module accum_shift1
   import accum_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] value_in,
   input  acc_op_e          op,
   output logic [WIDTH-1:0] value_out,
   output logic             carry_out
);

   always_comb begin
      value_out = value_in;
      carry_out = 1'b0;
      case (op)
         OP_SHL: begin
            carry_out = value_in[WIDTH-1];
            value_out = {value_in[WIDTH-2:0], 1'b0};
         end
         OP_SHR: begin
            carry_out = value_in[0];
            value_out = {1'b0, value_in[WIDTH-1:1]};
         end
         OP_ROL: begin
            carry_out = value_in[WIDTH-1];
            value_out = {value_in[WIDTH-2:0], value_in[WIDTH-1]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/accum_bank.sv
// Multi-accumulator register bank with clear/inc/dec/load and multi-cycle
// shift/rotate. Define ACCUM_SAT_EN for saturating INC/DEC instead of wrap.
module accum_bank
   import accum_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int N_ACC = DEFAULT_N_ACC,
   localparam int SEL_W = sel_width(N_ACC),
   localparam int SH_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] z,
   input  logic             start,
   input  acc_op_e          op,
   input  logic [SEL_W-1:0] sel,
   input  logic [SH_W-1:0]  shamt,
   output logic             busy,
   output logic [WIDTH-1:0] ac,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
);

   acc_state_e       state_q, state_d;
   logic [WIDTH-1:0] acc_q [N_ACC];
   logic [WIDTH-1:0] acc_d [N_ACC];
   acc_op_e          op_q, op_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SH_W-1:0]  cnt_q, cnt_d;
   logic             z_q, z_d;
   logic             n_q, n_d;
   logic             c_q, c_d;

   logic             sel_ok;
   logic [WIDTH-1:0] shift_in;
   logic [WIDTH-1:0] shift_out;
   logic             shift_co;
   logic [WIDTH-1:0] res_val;
   logic             res_wr;

   assign sel_ok = (int'(sel) < N_ACC);

   // Live read port; an out-of-range select reads as zero.
   always_comb begin
      ac = '0;
      for (int i = 0; i < N_ACC; i++) begin
         if (sel == SEL_W'(i)) ac = acc_q[i];
      end
   end

   always_comb begin
      shift_in = '0;
      for (int i = 0; i < N_ACC; i++) begin
         if (sel_q == SEL_W'(i)) shift_in = acc_q[i];
      end
   end

   accum_shift1 #(.WIDTH(WIDTH)) u_shift1 (
      .value_in  (shift_in),
      .op        (op_q),
      .value_out (shift_out),
      .carry_out (shift_co)
   );

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred; blocking '=' is correct here.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      z_d     = z_q;
      n_d     = n_q;
      c_d     = c_q;
      res_val = ac;
      res_wr  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && sel_ok && (op != OP_NOP)) begin
               case (op)
                  OP_LOAD: begin
                     res_val = z;
                     res_wr  = 1'b1;
                     c_d     = 1'b0;
                  end
                  OP_CLR: begin
                     res_val = '0;
                     res_wr  = 1'b1;
                     c_d     = 1'b0;
                  end
                  OP_INC: begin
                     res_wr = 1'b1;
`ifdef ACCUM_SAT_EN
                     c_d     = (ac == '1);
                     res_val = (ac == '1) ? ac : ac + WIDTH'(1);
`else
                     {c_d, res_val} = {1'b0, ac} + (WIDTH+1)'(1);
`endif
                  end
                  OP_DEC: begin
                     res_wr = 1'b1;
                     c_d    = (ac == '0);
`ifdef ACCUM_SAT_EN
                     res_val = (ac == '0) ? ac : ac - WIDTH'(1);
`else
                     res_val = ac - WIDTH'(1);
`endif
                  end
                  default: begin
                     // Shift/rotate: zero count completes now, else run the FSM.
                     if (shamt == '0) begin
                        res_wr = 1'b1;
                        c_d    = 1'b0;
                     end else begin
                        op_d    = op;
                        sel_d   = sel;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                     end
                  end
               endcase
            end

            if (res_wr) begin
               for (int i = 0; i < N_ACC; i++) begin
                  if (sel == SEL_W'(i)) acc_d[i] = res_val;
               end
               z_d = (res_val == '0);
               n_d = res_val[WIDTH-1];
            end
         end

         SHIFT: begin
            for (int i = 0; i < N_ACC; i++) begin
               if (sel_q == SEL_W'(i)) acc_d[i] = shift_out;
            end
            c_d   = shift_co;
            cnt_d = cnt_q - SH_W'(1);
            if (cnt_q == SH_W'(1)) begin
               state_d = IDLE;
               z_d     = (shift_out == '0);
               n_d     = shift_out[WIDTH-1];
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking '<=' so every flop samples the
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         // NOTE: the bank is small and must read zero after reset, so it is
         // reset like ordinary flops rather than treated as an unreset RAM.
         acc_q   <= '{default: '0};
         op_q    <= OP_NOP;
         sel_q   <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b1;
         n_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         n_q     <= n_d;
         c_q     <= c_d;
      end
   end

   assign busy   = (state_q == SHIFT);
   assign flag_z = z_q;
   assign flag_n = n_q;
   assign flag_c = c_q;

endmodule

// File: tb/tb_accum_bank.sv
// Directed, table-driven bench for accum_bank (WIDTH=8, N_ACC=4) plus a
// 3-entry instance for out-of-range select behaviour.
module tb_accum_bank;
   import accum_pkg::*;

`ifdef ACCUM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] z = '0;
   logic       start = 1'b0;
   acc_op_e    op = OP_NOP;
   logic [1:0] sel = '0;
   logic [2:0] shamt = '0;

   logic       busy, flag_z, flag_n, flag_c;
   logic [7:0] ac;
   logic       busy3, flag_z3, flag_n3, flag_c3;
   logic [7:0] ac3;

   int n_vec = 0;
   int n_bad = 0;
   int cycles;

   always #5 clk = ~clk;

   accum_bank #(.WIDTH(8), .N_ACC(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .z(z), .start(start), .op(op), .sel(sel),
      .shamt(shamt), .busy(busy), .ac(ac), .flag_z(flag_z), .flag_n(flag_n),
      .flag_c(flag_c)
   );

   accum_bank #(.WIDTH(8), .N_ACC(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .z(z), .start(start), .op(op), .sel(sel),
      .shamt(shamt), .busy(busy3), .ac(ac3), .flag_z(flag_z3), .flag_n(flag_n3),
      .flag_c(flag_c3)
   );

   typedef struct {
      logic       start;
      acc_op_e    op;
      logic [1:0] sel;
      logic [7:0] z;
      logic [2:0] shamt;
      logic [7:0] exp_ac;
      logic [2:0] exp_znc;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One-cycle command: drive at a falling edge, sampled by the next rising edge.
   task automatic cmd(input logic s, input acc_op_e o, input logic [1:0] sl,
                      input logic [7:0] zv, input logic [2:0] sh);
      @(negedge clk);
      start = s; op = o; sel = sl; z = zv; shamt = sh;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
   endtask

   initial begin
      // Expected {Z,N,C} and values, tracking bank state across vectors.
      vecs[0]  = '{1'b1, OP_LOAD, 2'd1, 8'h80, 3'd0, 8'h80, 3'b010};
      vecs[1]  = '{1'b1, OP_LOAD, 2'd2, 8'hFF, 3'd0, 8'hFF, 3'b010};
      vecs[2]  = '{1'b1, OP_INC,  2'd2, 8'h00, 3'd0, SAT ? 8'hFF : 8'h00, SAT ? 3'b011 : 3'b101};
      vecs[3]  = '{1'b1, OP_DEC,  2'd2, 8'h00, 3'd0, SAT ? 8'hFE : 8'hFF, SAT ? 3'b010 : 3'b011};
      vecs[4]  = '{1'b1, OP_DEC,  2'd0, 8'h00, 3'd0, SAT ? 8'h00 : 8'hFF, SAT ? 3'b101 : 3'b011};
      vecs[5]  = '{1'b1, OP_NOP,  2'd1, 8'h12, 3'd0, 8'h80, SAT ? 3'b101 : 3'b011};
      vecs[6]  = '{1'b0, OP_LOAD, 2'd1, 8'hEE, 3'd0, 8'h80, SAT ? 3'b101 : 3'b011};
      vecs[7]  = '{1'b1, OP_INC,  2'd1, 8'h00, 3'd0, 8'h81, 3'b010};
      vecs[8]  = '{1'b1, OP_CLR,  2'd1, 8'h00, 3'd0, 8'h00, 3'b100};
      vecs[9]  = '{1'b1, OP_LOAD, 2'd1, 8'h01, 3'd0, 8'h01, 3'b000};
      vecs[10] = '{1'b1, OP_DEC,  2'd1, 8'h00, 3'd0, 8'h00, 3'b100};
      vecs[11] = '{1'b1, OP_LOAD, 2'd3, 8'hFF, 3'd0, 8'hFF, 3'b010};
      vecs[12] = '{1'b1, OP_INC,  2'd3, 8'h00, 3'd0, SAT ? 8'hFF : 8'h00, SAT ? 3'b011 : 3'b101};
      vecs[13] = '{1'b1, OP_SHR,  2'd0, 8'h00, 3'd0, SAT ? 8'h00 : 8'hFF, SAT ? 3'b100 : 3'b010};
      vecs[14] = '{1'b1, OP_ROL,  2'd2, 8'h00, 3'd0, SAT ? 8'hFE : 8'hFF, 3'b010};
      vecs[15] = '{1'b1, OP_LOAD, 2'd3, 8'h7F, 3'd0, 8'h7F, 3'b000};

      // Reset state
      repeat (2) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         check($sformatf("reset ac[%0d]", s), 32'(ac), 32'h00);
      end
      check("reset flags", 32'({flag_z, flag_n, flag_c}), 32'b100);
      check("reset busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Out-of-range select on the 3-entry bank is ignored and reads zero
      cmd(1'b1, OP_LOAD, 2'd3, 8'h55, 3'd0);
      check("oor main ac[3]", 32'(ac), 32'h55);
      check("oor dut3 ac", 32'(ac3), 32'h00);
      check("oor dut3 flags", 32'({flag_z3, flag_n3, flag_c3}), 32'b100);
      cmd(1'b1, OP_LOAD, 2'd2, 8'hAA, 3'd0);
      check("dut3 ac[2]", 32'(ac3), 32'hAA);
      sel = 2'd3; #1;
      check("dut3 ac[3] after", 32'(ac3), 32'h00);

      for (int i = 0; i < 16; i++) begin
         cmd(vecs[i].start, vecs[i].op, vecs[i].sel, vecs[i].z, vecs[i].shamt);
         check($sformatf("v%0d ac", i), 32'(ac), 32'(vecs[i].exp_ac));
         check($sformatf("v%0d flags", i), 32'({flag_z, flag_n, flag_c}), 32'(vecs[i].exp_znc));
         check($sformatf("v%0d busy", i), 32'(busy), 32'd0);
      end

      // Untargeted accumulators keep their values
      sel = 2'd0; #1; check("final ac[0]", 32'(ac), SAT ? 32'h00 : 32'hFF);
      sel = 2'd1; #1; check("final ac[1]", 32'(ac), 32'h00);
      sel = 2'd2; #1; check("final ac[2]", 32'(ac), SAT ? 32'hFE : 32'hFF);

      // SHL by 3 with an ignored mid-shift start
      cmd(1'b1, OP_LOAD, 2'd1, 8'hB1, 3'd0);
      start = 1'b1; op = OP_SHL; sel = 2'd1; shamt = 3'd3;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      check("shl busy0", 32'(busy), 32'd1);
      check("shl ac0", 32'(ac), 32'hB1);
      @(negedge clk);
      check("shl ac1", 32'(ac), 32'h62);
      check("shl busy1", 32'(busy), 32'd1);
      start = 1'b1; op = OP_LOAD; z = 8'h00;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      check("shl ac2", 32'(ac), 32'hC4);
      check("shl busy2", 32'(busy), 32'd1);
      @(negedge clk);
      check("shl ac3", 32'(ac), 32'h88);
      check("shl busy3", 32'(busy), 32'd0);
      check("shl flags", 32'({flag_z, flag_n, flag_c}), 32'b011);
      @(negedge clk);
      check("shl no queue", 32'(ac), 32'h88);

      // ROL by 4, latency measured with a bounded wait
      cmd(1'b1, OP_LOAD, 2'd3, 8'h3C, 3'd0);
      start = 1'b1; op = OP_ROL; sel = 2'd3; shamt = 3'd4;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      cycles = 0;
      while (busy && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      check("rol cycles", 32'(cycles), 32'd4);
      check("rol ac", 32'(ac), 32'hC3);
      check("rol flags", 32'({flag_z, flag_n, flag_c}), 32'b011);

      // Reset in the middle of SHR by 5
      cmd(1'b1, OP_LOAD, 2'd0, 8'hF0, 3'd0);
      start = 1'b1; op = OP_SHR; sel = 2'd0; shamt = 3'd5;
      @(negedge clk);
      start = 1'b0; op = OP_NOP;
      repeat (2) @(negedge clk);
      check("shr mid ac", 32'(ac), 32'h3C);
      rst_n = 1'b0; #1;
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst flags", 32'({flag_z, flag_n, flag_c}), 32'b100);
      for (int s = 0; s < 4; s++) begin
         sel = 2'(s); #1;
         check($sformatf("mid rst ac[%0d]", s), 32'(ac), 32'h00);
      end
      @(negedge clk);
      rst_n = 1'b1;
      cmd(1'b1, OP_LOAD, 2'd0, 8'h5A, 3'd0);
      check("post rst load", 32'(ac), 32'h5A);
      check("post rst flags", 32'({flag_z, flag_n, flag_c}), 32'b000);
      repeat (6) @(negedge clk);
      check("post rst busy", 32'(busy), 32'd0);
      check("post rst hold", 32'(ac), 32'h5A);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
